// File: rtl/drrip_pkg.sv
// Shared types and RRPV helpers for the DRRIP replacement engine.
package drrip_pkg;

  typedef enum logic [1:0] {
    OP_HIT   = 2'b00,
    OP_MISS  = 2'b01,
    OP_INVAL = 2'b10,
    OP_RSVD  = 2'b11
  } req_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOOKUP = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  function automatic int unsigned rrpv_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

  function automatic int unsigned rrpv_long(input int unsigned bits);
    return rrpv_max(bits) - 32'd1;
  endfunction

endpackage

// File: rtl/drrip_repl_engine_if.sv
// Request/response channels and PSEL observation bus of the DRRIP engine.
interface drrip_repl_engine_if #(
  parameter int unsigned NUM_WAYS    = 16,
  parameter int unsigned NUM_SETS    = 128,
  parameter int unsigned NUM_THREADS = 2,
  parameter int unsigned PSEL_BITS   = 10
);
  localparam int unsigned WAY_W = $clog2(NUM_WAYS);
  localparam int unsigned SET_W = $clog2(NUM_SETS);
  localparam int unsigned THR_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  logic                             req_valid;
  logic                             req_ready;
  logic [1:0]                       req_op;
  logic [SET_W-1:0]                 req_set;
  logic [WAY_W-1:0]                 req_way;
  logic [THR_W-1:0]                 req_thread;
  logic                             resp_valid;
  logic                             resp_ready;
  logic [WAY_W-1:0]                 resp_way;
  logic                             resp_brrip;
  logic [NUM_THREADS*PSEL_BITS-1:0] psel_out;

  modport master (
    output req_valid, req_op, req_set, req_way, req_thread, resp_ready,
    input  req_ready, resp_valid, resp_way, resp_brrip, psel_out
  );

  modport slave (
    input  req_valid, req_op, req_set, req_way, req_thread, resp_ready,
    output req_ready, resp_valid, resp_way, resp_brrip, psel_out
  );

endinterface

// File: rtl/drrip_victim_sel.sv
// Single-step victim search: lowest invalid way, else lowest way at max RRPV
// with the whole set pre-aged so that maximum reaches RRPV_MAX.
module drrip_victim_sel
  import drrip_pkg::*;
#(
  parameter int unsigned NUM_WAYS  = 16,
  parameter int unsigned RRPV_BITS = 2
) (
  input  logic [NUM_WAYS-1:0][RRPV_BITS-1:0] rrpv_i,
  input  logic [NUM_WAYS-1:0]                valid_i,
  output logic [$clog2(NUM_WAYS)-1:0]        victim_o,
  output logic                               inv_found_o,
  output logic [NUM_WAYS-1:0][RRPV_BITS-1:0] aged_o
);
  localparam int unsigned WAY_W = $clog2(NUM_WAYS);
  localparam logic [RRPV_BITS-1:0] RRPV_MAX_V = RRPV_BITS'(rrpv_max(RRPV_BITS));

  logic [WAY_W-1:0]     inv_way;
  logic [WAY_W-1:0]     max_way;
  logic                 max_found;
  logic [RRPV_BITS-1:0] max_rrpv;
  logic [RRPV_BITS-1:0] delta;

  always_comb begin
    inv_found_o = 1'b0;
    inv_way     = '0;
    max_rrpv    = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!valid_i[w] && !inv_found_o) begin
        inv_found_o = 1'b1;
        inv_way     = WAY_W'(w);
      end
      if (rrpv_i[w] > max_rrpv) max_rrpv = rrpv_i[w];
    end

    // Adding the headroom once is the same as aging until some way saturates.
    delta     = RRPV_MAX_V - max_rrpv;
    max_found = 1'b0;
    max_way   = '0;
    aged_o    = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      aged_o[w] = rrpv_i[w] + delta;
      if (rrpv_i[w] == max_rrpv && !max_found) begin
        max_found = 1'b1;
        max_way   = WAY_W'(w);
      end
    end

    victim_o = inv_found_o ? inv_way : max_way;
  end

endmodule

// File: rtl/drrip_repl_engine.sv
// Thread-aware DRRIP replacement engine: per-set RRPV/valid state, per-thread
// set-dueling PSEL, global BIP counter, IDLE/LOOKUP/RESP request FSM.
module drrip_repl_engine
  import drrip_pkg::*;
#(
  parameter int unsigned NUM_WAYS     = 16,
  parameter int unsigned NUM_SETS     = 128,
  parameter int unsigned RRPV_BITS    = 2,
  parameter int unsigned PSEL_BITS    = 10,
  parameter int unsigned NUM_THREADS  = 2,
  parameter int unsigned LEADER_BITS  = 5,
  parameter int unsigned BIP_LOG2_EPS = 5,
  parameter int unsigned HP_MODE      = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  drrip_repl_engine_if.slave   bus
);
  localparam int unsigned WAY_W = $clog2(NUM_WAYS);
  localparam int unsigned SET_W = $clog2(NUM_SETS);
  localparam int unsigned THR_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  localparam logic [RRPV_BITS-1:0] RRPV_MAX_V  = RRPV_BITS'(rrpv_max(RRPV_BITS));
  localparam logic [RRPV_BITS-1:0] RRPV_LONG_V = RRPV_BITS'(rrpv_long(RRPV_BITS));
  localparam logic [PSEL_BITS-1:0] PSEL_MID    = {1'b1, {(PSEL_BITS-1){1'b0}}};

  typedef logic [NUM_WAYS-1:0][RRPV_BITS-1:0] row_t;

  state_e                  state_q, state_d;
  req_op_e                 op_q, op_d;
  logic [SET_W-1:0]        set_q, set_d;
  logic [WAY_W-1:0]        way_q, way_d;
  logic [THR_W-1:0]        thr_q, thr_d;
  row_t                    rrpv_q [NUM_SETS];
  logic [NUM_WAYS-1:0]     valid_q [NUM_SETS];
  logic [PSEL_BITS-1:0]    psel_q [NUM_THREADS];
  logic [PSEL_BITS-1:0]    psel_d [NUM_THREADS];
  logic [BIP_LOG2_EPS-1:0] bip_q, bip_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [WAY_W-1:0]        resp_way_q, resp_way_d;
  logic                    resp_brrip_q, resp_brrip_d;

  row_t                    row_d;
  logic [NUM_WAYS-1:0]     vrow_d;
  logic                    row_we;

  row_t                    cur_row;
  logic [NUM_WAYS-1:0]     cur_vld;
  row_t                    aged_row;
  logic [WAY_W-1:0]        vic_way;
  logic                    inv_found;

  logic [LEADER_BITS-1:0]  lset;
  logic [LEADER_BITS-1:0]  lbase;
  logic                    srrip_ldr;
  logic                    brrip_ldr;
  logic                    use_brrip;

  assign cur_row = rrpv_q[set_q];
  assign cur_vld = valid_q[set_q];

  drrip_victim_sel #(
    .NUM_WAYS  (NUM_WAYS),
    .RRPV_BITS (RRPV_BITS)
  ) u_victim_sel (
    .rrpv_i      (cur_row),
    .valid_i     (cur_vld),
    .victim_o    (vic_way),
    .inv_found_o (inv_found),
    .aged_o      (aged_row)
  );

  // Thread t leads sets 2t (SRRIP) and 2t+1 (BRRIP); others follow its PSEL.
  assign lset      = set_q[LEADER_BITS-1:0];
  assign lbase     = LEADER_BITS'({thr_q, 1'b0});
  assign srrip_ldr = (lset == lbase);
  assign brrip_ldr = (lset == (lbase | LEADER_BITS'(1)));
  assign use_brrip = brrip_ldr || (!srrip_ldr && (psel_q[thr_q] > PSEL_MID));

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_way   = resp_way_q;
  assign bus.resp_brrip = resp_brrip_q;

  always_comb begin
    bus.psel_out = '0;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      bus.psel_out[t*PSEL_BITS +: PSEL_BITS] = psel_q[t];
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    set_d        = set_q;
    way_d        = way_q;
    thr_d        = thr_q;
    psel_d       = psel_q;
    bip_d        = bip_q;
    resp_valid_d = resp_valid_q;
    resp_way_d   = resp_way_q;
    resp_brrip_d = resp_brrip_q;
    row_d        = cur_row;
    vrow_d       = cur_vld;
    row_we       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          op_d    = req_op_e'(bus.req_op);
          set_d   = bus.req_set;
          way_d   = bus.req_way;
          thr_d   = bus.req_thread;
          state_d = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        state_d = ST_IDLE;
        unique case (op_q)
          OP_HIT: begin
            row_we = 1'b1;
            if (HP_MODE == 0) begin
              row_d[way_q] = '0;
            end else if (cur_row[way_q] != '0) begin
              row_d[way_q] = cur_row[way_q] - RRPV_BITS'(1);
            end
          end
          OP_INVAL: begin
            row_we        = 1'b1;
            row_d[way_q]  = RRPV_MAX_V;
            vrow_d[way_q] = 1'b0;
          end
          OP_MISS: begin
            row_we = 1'b1;
            if (!inv_found) row_d = aged_row;
            vrow_d[vic_way] = 1'b1;
            if (use_brrip) begin
              row_d[vic_way] = (bip_q == '0) ? RRPV_LONG_V : RRPV_MAX_V;
              bip_d          = bip_q + BIP_LOG2_EPS'(1);
            end else begin
              row_d[vic_way] = RRPV_LONG_V;
            end
            if (srrip_ldr && psel_q[thr_q] != '1) begin
              psel_d[thr_q] = psel_q[thr_q] + PSEL_BITS'(1);
            end else if (brrip_ldr && psel_q[thr_q] != '0) begin
              psel_d[thr_q] = psel_q[thr_q] - PSEL_BITS'(1);
            end
            resp_valid_d = 1'b1;
            resp_way_d   = vic_way;
            resp_brrip_d = use_brrip;
            state_d      = ST_RESP;
          end
          default: ;
        endcase
      end

      ST_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_HIT;
      set_q        <= '0;
      way_q        <= '0;
      thr_q        <= '0;
      bip_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_way_q   <= '0;
      resp_brrip_q <= 1'b0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        rrpv_q[s]  <= '1;
        valid_q[s] <= '0;
      end
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        psel_q[t] <= PSEL_MID;
      end
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      set_q        <= set_d;
      way_q        <= way_d;
      thr_q        <= thr_d;
      bip_q        <= bip_d;
      resp_valid_q <= resp_valid_d;
      resp_way_q   <= resp_way_d;
      resp_brrip_q <= resp_brrip_d;
      psel_q       <= psel_d;
      if (row_we) begin
        rrpv_q[set_q]  <= row_d;
        valid_q[set_q] <= vrow_d;
      end
    end
  end

endmodule
